// File: rtl/flght_pkg.sv
// +----------------------------------------------------------------------------+
// | flght_pkg : shared types, widths and saturation helpers for flght_pd_seq   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package flght_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR  = 2'd1,
    TERM = 2'd2,
    MIX  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PTCH = 2'd0,
    ROLL = 2'd1,
    YAW  = 2'd2
  } axis_t;

  localparam int MEAS_W  = 16;
  localparam int ERR_W   = 10;
  localparam int DDIFF_W = 7;
  localparam int SPD_W   = 11;
  localparam int P_W     = 10;
  localparam int D_W     = 12;
  localparam int SUM_W   = 14;
  localparam logic [SPD_W-1:0] SPD_MAX = 11'h7FF;

  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [MEAS_W:0] x);
    if (x > 17'sd511)       return 10'sd511;
    else if (x < -17'sd512) return -10'sd512;
    else                    return ERR_W'(x);
  endfunction

  function automatic logic signed [DDIFF_W-1:0] sat_ddiff(input logic signed [ERR_W:0] x);
    if (x > 11'sd63)       return 7'sd63;
    else if (x < -11'sd64) return -7'sd64;
    else                   return DDIFF_W'(x);
  endfunction

  function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [SUM_W-1:0] x);
    if (x < 14'sd0)         return '0;
    else if (x > 14'sd2047) return SPD_MAX;
    else                    return SPD_W'(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/err_hist_queue.sv
// +----------------------------------------------------------------------------+
// | err_hist_queue : per-axis error history shift register, oldest entry out   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module err_hist_queue #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] oldest_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign oldest_o = mem_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/flght_pd_seq.sv
// +----------------------------------------------------------------------------+
// | flght_pd_seq : 3-axis PD attitude controller with motor mixing, one shared |
// | datapath stepped axis by axis. Option FLGHT_OVERRUN_CNT_EN adds ovr_cnt.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module flght_pd_seq
  import flght_pkg::*;
#(
  parameter int          D_QUEUE_DEPTH = 12,
  parameter logic [5:0]  DTERM         = 6'd7,
  parameter logic [10:0] MIN_RUN_SPEED = 11'h2C0,
  parameter logic [10:0] CAL_SPEED     = 11'h1B0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vld,
  input  logic signed [15:0] ptch,
  input  logic signed [15:0] roll,
  input  logic signed [15:0] yaw,
  input  logic signed [15:0] d_ptch,
  input  logic signed [15:0] d_roll,
  input  logic signed [15:0] d_yaw,
  input  logic [8:0]         thrst,
  input  logic               inertial_cal,
  output logic [10:0]        frnt_spd,
  output logic [10:0]        bck_spd,
  output logic [10:0]        lft_spd,
  output logic [10:0]        rght_spd,
`ifdef FLGHT_OVERRUN_CNT_EN
  output logic [7:0]         ovr_cnt,
`endif
  output logic               spd_vld
);

  state_t                    state_q;
  axis_t                     axis_q;
  logic signed [MEAS_W-1:0]  meas_q [3];
  logic signed [MEAS_W-1:0]  des_q  [3];
  logic [8:0]                thrst_q;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic signed [P_W-1:0]     p_q [3];
  logic signed [P_W-1:0]     p_d;
  logic signed [D_W-1:0]     d_q [3];
  logic signed [D_W-1:0]     d_d;
  logic [SPD_W-1:0]          frnt_q, bck_q, lft_q, rght_q;
  logic [SPD_W-1:0]          frnt_d, bck_d, lft_d, rght_d;
  logic                      spd_vld_q;
  logic [ERR_W-1:0]          hist_old [3];
  logic [2:0]                hist_push;

  logic signed [MEAS_W-1:0]  meas_sel, des_sel;
  logic [ERR_W-1:0]          old_sel;
  logic signed [MEAS_W:0]    err_raw;
  logic signed [12:0]        p_prod;
  logic signed [ERR_W:0]     ddiff;
  logic signed [DDIFF_W-1:0] ddiff_sat;
  logic signed [SUM_W-1:0]   base, t_p, t_r, t_y;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hist
      assign hist_push[gi] = (state_q == TERM) && (axis_q == axis_t'(gi));
      err_hist_queue #(
        .DEPTH (D_QUEUE_DEPTH),
        .WIDTH (ERR_W)
      ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_i   (hist_push[gi]),
        .clr_i    (inertial_cal),
        .din_i    (err_q),
        .oldest_o (hist_old[gi])
      );
    end
  endgenerate

  always_comb begin
    meas_sel = meas_q[0];
    des_sel  = des_q[0];
    old_sel  = hist_old[0];
    case (axis_q)
      ROLL:    begin meas_sel = meas_q[1]; des_sel = des_q[1]; old_sel = hist_old[1]; end
      YAW:     begin meas_sel = meas_q[2]; des_sel = des_q[2]; old_sel = hist_old[2]; end
      default: ;
    endcase

    err_raw   = $signed({meas_sel[MEAS_W-1], meas_sel}) - $signed({des_sel[MEAS_W-1], des_sel});
    err_d     = sat_err(err_raw);

    p_prod    = $signed({{3{err_q[ERR_W-1]}}, err_q}) * 13'sd5;
    p_d       = P_W'(p_prod >>> 3);
    ddiff     = $signed({err_q[ERR_W-1], err_q}) - $signed({old_sel[ERR_W-1], old_sel});
    ddiff_sat = sat_ddiff(ddiff);
    d_d       = $signed({{5{ddiff_sat[DDIFF_W-1]}}, ddiff_sat}) * $signed({6'd0, DTERM});

    // Each axis contributes P+D as one signed term to the mix
    base = $signed({5'd0, thrst_q}) + $signed({3'd0, MIN_RUN_SPEED});
    t_p  = $signed({{4{p_q[0][P_W-1]}}, p_q[0]}) + $signed({{2{d_q[0][D_W-1]}}, d_q[0]});
    t_r  = $signed({{4{p_q[1][P_W-1]}}, p_q[1]}) + $signed({{2{d_q[1][D_W-1]}}, d_q[1]});
    t_y  = $signed({{4{p_q[2][P_W-1]}}, p_q[2]}) + $signed({{2{d_q[2][D_W-1]}}, d_q[2]});

    frnt_d = clamp_spd(base + t_p - t_y);
    bck_d  = clamp_spd(base - t_p - t_y);
    lft_d  = clamp_spd(base - t_r + t_y);
    rght_d = clamp_spd(base + t_r + t_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      axis_q    <= PTCH;
      thrst_q   <= '0;
      err_q     <= '0;
      frnt_q    <= '0;
      bck_q     <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      spd_vld_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        meas_q[i] <= '0;
        des_q[i]  <= '0;
        p_q[i]    <= '0;
        d_q[i]    <= '0;
      end
    end else begin
      spd_vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vld) begin
            meas_q[0] <= ptch;   meas_q[1] <= roll;   meas_q[2] <= yaw;
            des_q[0]  <= d_ptch; des_q[1]  <= d_roll; des_q[2]  <= d_yaw;
            thrst_q   <= thrst;
            axis_q    <= PTCH;
            state_q   <= ERR;
          end
        end
        ERR: begin
          err_q   <= err_d;
          state_q <= TERM;
        end
        TERM: begin
          case (axis_q)
            PTCH: begin p_q[0] <= p_d; d_q[0] <= d_d; axis_q <= ROLL; state_q <= ERR; end
            ROLL: begin p_q[1] <= p_d; d_q[1] <= d_d; axis_q <= YAW;  state_q <= ERR; end
            YAW:  begin p_q[2] <= p_d; d_q[2] <= d_d; axis_q <= PTCH; state_q <= MIX; end
            default: state_q <= IDLE;
          endcase
        end
        MIX: begin
          frnt_q    <= frnt_d;
          bck_q     <= bck_d;
          lft_q     <= lft_d;
          rght_q    <= rght_d;
          spd_vld_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Calibration overrides whatever the mix produced
      if (inertial_cal) begin
        frnt_q <= CAL_SPEED;
        bck_q  <= CAL_SPEED;
        lft_q  <= CAL_SPEED;
        rght_q <= CAL_SPEED;
      end
    end
  end

`ifdef FLGHT_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_q <= '0;
    end else if (vld && (state_q != IDLE) && (ovr_cnt_q != 8'hFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign ovr_cnt = ovr_cnt_q;
`endif

  assign frnt_spd = frnt_q;
  assign bck_spd  = bck_q;
  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign spd_vld  = spd_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_flght_pd_seq.sv
// +----------------------------------------------------------------------------+
// | tb_flght_pd_seq : self-checking bench for flght_pd_seq                     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_flght_pd_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic signed [15:0] ptch, roll, yaw, d_ptch, d_roll, d_yaw;
  logic [8:0]         thrst;
  logic               inertial_cal;
  logic [10:0]        frnt_spd, bck_spd, lft_spd, rght_spd;
  logic               spd_vld;
`ifdef FLGHT_OVERRUN_CNT_EN
  logic [7:0]         ovr_cnt;
`endif

  always #5 clk = ~clk;

  flght_pd_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vld          (vld),
    .ptch         (ptch),
    .roll         (roll),
    .yaw          (yaw),
    .d_ptch       (d_ptch),
    .d_roll       (d_roll),
    .d_yaw        (d_yaw),
    .thrst        (thrst),
    .inertial_cal (inertial_cal),
    .frnt_spd     (frnt_spd),
    .bck_spd      (bck_spd),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
`ifdef FLGHT_OVERRUN_CNT_EN
    .ovr_cnt      (ovr_cnt),
`endif
    .spd_vld      (spd_vld)
  );

  typedef struct {
    int ptch, roll, yaw, dp, dr, dy, thrst;
  } sample_t;

  typedef struct {
    sample_t s;
    int      ef, eb, el, er;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  int hq [3][$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Reference: 12-deep FIFO of saturated errors per axis, all zero after reset/cal
  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      hq[a].delete();
      repeat (12) hq[a].push_back(0);
    end
  endtask

  task automatic model_sample(input sample_t s, output int f, output int b, output int l, output int r);
    int m [3];
    int d [3];
    int t [3];
    int e, old, base;
    m[0] = s.ptch; m[1] = s.roll; m[2] = s.yaw;
    d[0] = s.dp;   d[1] = s.dr;   d[2] = s.dy;
    for (int a = 0; a < 3; a++) begin
      e   = sat(m[a] - d[a], -512, 511);
      old = hq[a].pop_front();
      hq[a].push_back(e);
      t[a] = ((e * 5) >>> 3) + sat(e - old, -64, 63) * 7;
    end
    base = s.thrst + 'h2C0;
    f = sat(base + t[0] - t[2], 0, 2047);
    b = sat(base - t[0] - t[2], 0, 2047);
    l = sat(base - t[1] + t[2], 0, 2047);
    r = sat(base + t[1] + t[2], 0, 2047);
  endtask

  task automatic drive(input sample_t s);
    ptch   = 16'(s.ptch); roll   = 16'(s.roll); yaw   = 16'(s.yaw);
    d_ptch = 16'(s.dp);   d_roll = 16'(s.dr);   d_yaw = 16'(s.dy);
    thrst  = 9'(s.thrst);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; vld = 1'b0; inertial_cal = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic run_sample(input sample_t s, input bit cal_v,
                            output int f, output int b, output int l, output int r);
    int lat;
    bit seen;
    @(negedge clk);
    drive(s);
    inertial_cal = cal_v;
    vld = 1'b1;
    @(negedge clk);
    vld  = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (spd_vld) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk("latency", seen ? lat : -1, 8);
    f = frnt_spd; b = bck_spd; l = lft_spd; r = rght_spd;
    @(negedge clk);
    chk("spd_vld_one_cycle", int'(spd_vld), 0);
  endtask

  task automatic chk4(input string nm, input int f, input int b, input int l, input int r,
                      input int ef, input int eb, input int el, input int er);
    chk({nm, "_frnt"}, f, ef);
    chk({nm, "_bck"},  b, eb);
    chk({nm, "_lft"},  l, el);
    chk({nm, "_rght"}, r, er);
  endtask

  initial begin
    vec_t    tbl [5];
    sample_t s;
    int      f, b, l, r, ef, eb, el, er, cnt;

    tbl[0] = '{'{0, 0, 0, 0, 0, 0, 'h100},        960,  960,  960,  960};
    tbl[1] = '{'{100, 0, 0, 0, 0, 0, 'h100},     1463,  457,  960,  960};
    tbl[2] = '{'{5000, 0, -5000, 0, 0, 0, 511},  2047, 1223,  447,  447};
    tbl[3] = '{'{-5000, 0, 0, 0, 0, 0, 0},          0, 1472,  704,  704};
    tbl[4] = '{'{0, 0, 0, 0, -30, 0, 'h80},       832,  832,  604, 1060};

    rst_n = 1'b0; vld = 1'b0; inertial_cal = 1'b0;
    s = '{0, 0, 0, 0, 0, 0, 0};
    drive(s);
    repeat (3) @(negedge clk);
    chk4("reset", frnt_spd, bck_spd, lft_spd, rght_spd, 0, 0, 0, 0);
    chk("reset_spd_vld", int'(spd_vld), 0);
`ifdef FLGHT_OVERRUN_CNT_EN
    chk("reset_ovr_cnt", int'(ovr_cnt), 0);
`endif
    rst_n = 1'b1;
    model_clear();

    for (int i = 0; i < 5; i++) begin
      do_reset();
      run_sample(tbl[i].s, 1'b0, f, b, l, r);
      model_sample(tbl[i].s, ef, eb, el, er);
      chk4($sformatf("vec%0d", i), f, b, l, r, tbl[i].ef, tbl[i].eb, tbl[i].el, tbl[i].er);
    end

    // Derivative window: the 13th identical sample sees the 1st one
    do_reset();
    s = '{100, 0, 0, 0, 0, 0, 'h100};
    for (int p = 1; p <= 13; p++) begin
      run_sample(s, 1'b0, f, b, l, r);
      model_sample(s, ef, eb, el, er);
      chk($sformatf("window%0d_frnt", p), f, (p <= 12) ? 1463 : 1022);
    end

    @(negedge clk);
    vld = 1'b1; inertial_cal = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    chk("cal_immediate_frnt", int'(frnt_spd), 'h1B0);
    repeat (2) @(negedge clk);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("cal_spd_vld", int'(spd_vld), 1);
    chk4("cal", frnt_spd, bck_spd, lft_spd, rght_spd, 'h1B0, 'h1B0, 'h1B0, 'h1B0);
`ifdef FLGHT_OVERRUN_CNT_EN
    chk("ovr_cnt_drop", int'(ovr_cnt), 1);
`endif
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (spd_vld) cnt++;
    end
    chk("dropped_vld_no_pulse", cnt, 0);

    inertial_cal = 1'b0;
    model_clear();
    run_sample(s, 1'b0, f, b, l, r);
    model_sample(s, ef, eb, el, er);
    chk("post_cal_frnt", f, 1463);
    chk4("post_cal_model", f, b, l, r, ef, eb, el, er);

    @(negedge clk);
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk4("midreset", frnt_spd, bck_spd, lft_spd, rght_spd, 0, 0, 0, 0);
    chk("midreset_spd_vld", int'(spd_vld), 0);
`ifdef FLGHT_OVERRUN_CNT_EN
    chk("midreset_ovr_cnt", int'(ovr_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (spd_vld) cnt++;
    end
    chk("midreset_no_pulse", cnt, 0);

    for (int k = 0; k < 120; k++) begin
      s.ptch  = int'($urandom_range(1400, 0)) - 700;
      s.roll  = int'($urandom_range(1400, 0)) - 700;
      s.yaw   = int'($urandom_range(1400, 0)) - 700;
      s.dp    = int'($urandom_range(400, 0)) - 200;
      s.dr    = int'($urandom_range(400, 0)) - 200;
      s.dy    = int'($urandom_range(400, 0)) - 200;
      s.thrst = int'($urandom_range(511, 0));
      if (($urandom & 3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
      run_sample(s, 1'b0, f, b, l, r);
      model_sample(s, ef, eb, el, er);
      chk4($sformatf("rand%0d", k), f, b, l, r, ef, eb, el, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
